// File: rtl/ifetch_unit32_if.sv
// ifetch_unit32_if
//  Instruction-memory bus between the fetch stage and its instruction memory.
//  Signals:
//    imem_addr   word address issued by the fetch stage
//    imem_rdata  instruction word returned by memory
//  Modports:
//    master  fetch stage side (drives the address, receives data)
//    slave   memory side (receives the address, drives data)
//  imem_rdata must reflect the word at imem_addr by the end of the fetch
//  stage's ADDR cycle. A memory clocked on the falling edge meets this.
interface ifetch_unit32_if #(
  parameter int IMEM_ADDR_W = 14
);
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/ifetch_unit32.sv
// ifetch_unit32
//  Instruction-fetch stage. It holds the PC and reads a synchronous
//  instruction memory. It presents one registered Instruction per execute
//  slot and commits the next PC from the jump/branch decode.
//  Each instruction uses two cycles: an ADDR cycle issues the address, and
//  an EXEC cycle presents the instruction and commits the next PC.
//  Ports:
//    clock, reset        clock; synchronous active-high reset
//    stall               holds the EXEC slot (no commit)
//    Jr/Jmp/Jal          jump decode for the current Instruction
//    Branch/nBranch/Zero beq/bne decode and ALU zero flag
//    Addr_result         branch target
//    Read_data_1         jr target
//    imem                instruction-memory bus (master modport)
//    Instruction         current instruction, registered
//    instr_valid         high during the EXEC slot
//    PC                  address of Instruction
//    branch_base_addr    PC+4
//    link_addr           PC+4
//    instr_count         retired-instruction counter
//    fetch_fault         sticky alignment fault
//  Optional feature: define IFETCH_ALIGN_CHECK_EN to trap misaligned Jr or
//  branch targets. The trap enters a terminal S_FAULT state. When the macro
//  is undefined, target bits [1:0] are forced to zero and fetch_fault is 0.
module ifetch_unit32 #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  Jr,
  input  logic                  Jmp,
  input  logic                  Jal,
  input  logic                  Branch,
  input  logic                  nBranch,
  input  logic                  Zero,
  input  logic [31:0]           Addr_result,
  input  logic [31:0]           Read_data_1,
  ifetch_unit32_if.master       imem,
  output logic [31:0]           Instruction,
  output logic                  instr_valid,
  output logic [31:0]           PC,
  output logic [31:0]           branch_base_addr,
  output logic [31:0]           link_addr,
  output logic [31:0]           instr_count,
  output logic                  fetch_fault
);

  localparam logic [1:0] S_ADDR  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam logic [1:0] S_FAULT = 2'd2;
`endif

  logic [1:0]  state;
  logic [31:0] pc4;
  logic [31:0] raw_tgt;
  logic [31:0] next_pc;
  logic        br_taken;

  // Upper PC bits are dropped, so fetch wraps modulo the memory size.
  assign imem.imem_addr   = PC[IMEM_ADDR_W+1:2];
  assign pc4              = PC + 32'd4;
  assign branch_base_addr = pc4;
  assign link_addr        = pc4;
  assign br_taken         = (Branch & Zero) | (nBranch & ~Zero);

  always_comb begin
    raw_tgt = pc4;
    if (Jr)              raw_tgt = Read_data_1;
    else if (Jmp | Jal)  raw_tgt = {pc4[31:28], Instruction[25:0], 2'b00};
    else if (br_taken)   raw_tgt = Addr_result;
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Only Jr and branch targets can be misaligned. Jump targets and PC4 are
  // always word aligned.
  logic misalign;
  assign misalign = (raw_tgt[1:0] != 2'b00);
  assign next_pc  = raw_tgt;
`else
  assign next_pc  = raw_tgt & ~32'h3;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_ADDR;
      PC          <= RESET_PC;
      Instruction <= 32'h0;
      instr_valid <= 1'b0;
      instr_count <= 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      case (state)
        S_ADDR: begin
          Instruction <= imem.imem_rdata;
          instr_valid <= 1'b1;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          if (!stall) begin
`ifdef IFETCH_ALIGN_CHECK_EN
            if (misalign) begin
              // PC stays on the faulting instruction for post-mortem.
              fetch_fault <= 1'b1;
              instr_valid <= 1'b0;
              state       <= S_FAULT;
            end else begin
              PC          <= next_pc;
              instr_count <= instr_count + 32'd1;
              instr_valid <= 1'b0;
              state       <= S_ADDR;
            end
`else
            PC          <= next_pc;
            instr_count <= instr_count + 32'd1;
            instr_valid <= 1'b0;
            state       <= S_ADDR;
`endif
          end
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        S_FAULT: begin
          instr_valid <= 1'b0;
        end
`endif
        default: begin
          instr_valid <= 1'b0;
          state       <= S_ADDR;
        end
      endcase
    end
  end

`ifndef IFETCH_ALIGN_CHECK_EN
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit32.sv
module tb_ifetch_unit32;
  localparam int AW = 14;

  logic        clock = 1'b0;
  logic        reset, stall, Jr, Jmp, Jal, Branch, nBranch, Zero;
  logic [31:0] Addr_result, Read_data_1;
  logic [31:0] Instruction, PC, branch_base_addr, link_addr, instr_count;
  logic        instr_valid, fetch_fault;
  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  ifetch_unit32_if #(.IMEM_ADDR_W(AW)) imem ();

  ifetch_unit32 #(.RESET_PC(32'h0), .IMEM_ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .Jr(Jr), .Jmp(Jmp), .Jal(Jal), .Branch(Branch), .nBranch(nBranch),
    .Zero(Zero), .Addr_result(Addr_result), .Read_data_1(Read_data_1),
    .imem(imem.master), .Instruction(Instruction), .instr_valid(instr_valid),
    .PC(PC), .branch_base_addr(branch_base_addr), .link_addr(link_addr),
    .instr_count(instr_count), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // The memory is clocked on the falling edge. The word for the address
  // issued in an ADDR cycle is ready before that cycle's rising edge.
  always @(negedge clock) imem.imem_rdata <= mem[imem.imem_addr[7:0]];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_flags();
    Jr = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
    Addr_result = 0; Read_data_1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;
    mem[4] = 32'h0C00_0020;                 // jal, target field 0x20
    reset = 1; stall = 0; clr_flags();
    step(); step();
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    reset = 0;

    // Sequential fetch: PC 0,4,8,12 with instr_valid toggling.
    step(); chk("seq_v1", {31'h0, instr_valid}, 32'h1);
    chk("seq_addr0", {18'h0, imem.imem_addr}, 32'h0);
    step(); chk("seq_pc4", PC, 32'h4); chk("seq_v0", {31'h0, instr_valid}, 32'h0);
    step(); chk("seq_instr1", Instruction, 32'h1);
    step(); chk("seq_pc8", PC, 32'h8);
    step(); chk("seq_instr2", Instruction, 32'h2);
    step(); chk("seq_pc12", PC, 32'hC); chk("seq_cnt3", instr_count, 32'd3);

    // beq taken
    step(); chk("beq_instr3", Instruction, 32'h3);
    chk("beq_base", branch_base_addr, 32'h10);
    Branch = 1; Zero = 1; Addr_result = 32'h40;
    step(); chk("beq_taken_pc", PC, 32'h40); chk("beq_cnt", instr_count, 32'd4);
    clr_flags();

    // Decode is ignored in the ADDR cycle.
    Jr = 1; Read_data_1 = 32'h200;
    step(); chk("addr_ignore_pc", PC, 32'h40); chk("instr16", Instruction, 32'd16);
    clr_flags();

    // beq not taken
    Branch = 1; Zero = 0; Addr_result = 32'h80;
    step(); chk("beq_nt_pc", PC, 32'h44);
    clr_flags();

    // bne taken, back to the jal at 0x10
    step(); nBranch = 1; Zero = 0; Addr_result = 32'h10;
    step(); chk("bne_taken_pc", PC, 32'h10); chk("bne_cnt", instr_count, 32'd6);
    clr_flags();

    // jal
    step(); chk("jal_instr", Instruction, 32'h0C00_0020);
    chk("jal_link", link_addr, 32'h14);
    Jal = 1;
    step(); chk("jal_pc", PC, 32'h80);
    clr_flags();

    // Jr has priority over Jmp.
    step(); Jr = 1; Jmp = 1; Read_data_1 = 32'h100;
    step(); chk("jr_prio_pc", PC, 32'h100); chk("jr_cnt", instr_count, 32'd8);
    clr_flags();

    // Stall for 5 cycles in EXEC.
    step(); chk("stall_instr0", Instruction, 32'd64);
    stall = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_instr", Instruction, 32'd64);
      chk("stall_pc", PC, 32'h100);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_cnt", instr_count, 32'd8);
    end
    stall = 0;
    step(); chk("unstall_pc", PC, 32'h104); chk("unstall_cnt", instr_count, 32'd9);
    chk("unstall_valid", {31'h0, instr_valid}, 32'h0);

    // Misaligned Jr target
    step(); chk("mis_instr", Instruction, 32'd65);
    Jr = 1; Read_data_1 = 32'h102;
    step(); clr_flags();
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis_pc_hold", PC, 32'h104);
    chk("mis_cnt", instr_count, 32'd9);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fault_valid", {31'h0, instr_valid}, 32'h0);
      chk("fault_cnt", instr_count, 32'd9);
    end
`else
    chk("mis_pc", PC, 32'h100);
    chk("mis_fault0", {31'h0, fetch_fault}, 32'h0);
    chk("mis_cnt", instr_count, 32'd10);
`endif

    // PC4 wrap and address wrap
    reset = 1; step(); reset = 0;
    step(); Jr = 1; Read_data_1 = 32'hFFFF_FFFC;
    step(); clr_flags();
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pc4", branch_base_addr, 32'h0);
    chk("wrap_addr", {18'h0, imem.imem_addr}, 32'h3FFF);
    step(); chk("wrap_instr", Instruction, 32'd255);

    // Reset mid-EXEC while stalled
    stall = 1; step();
    chk("pre_rst_cnt", instr_count, 32'd1);
    reset = 1; step();
    chk("mid_rst_pc", PC, 32'h0);
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_cnt", instr_count, 32'h0);
    reset = 0; stall = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
